// File: rtl/ordered_issue_queue_if.sv
// Enqueue/dequeue bundle of the ordered issue queue.
// The queue takes the slave side; the producer/consumer takes the master side.
interface ordered_issue_queue_if #(
  parameter type dtype       = logic,
  parameter int  INPORT_NUM  = 4,
  parameter int  OUTPORT_NUM = 4,
  parameter int  DEPTH       = 16
);
  // i_enq_vld is accepted as a whole only while o_can_enq is high (never partially);
  // i_deq_req must be a thermometer prefix of o_deq_vld and retires that many window entries.
  logic                     i_flush;
  logic                     o_can_enq;
  logic [INPORT_NUM-1:0]    i_enq_vld;
  dtype                     i_enq_data [INPORT_NUM];
  logic [OUTPORT_NUM-1:0]   o_deq_vld;
  dtype                     o_deq_data [OUTPORT_NUM];
  logic [OUTPORT_NUM-1:0]   i_deq_req;
  logic [$clog2(DEPTH):0]   o_count;

  modport master (
    output i_flush, i_enq_vld, i_enq_data, i_deq_req,
    input  o_can_enq, o_deq_vld, o_deq_data, o_count
  );

  modport slave (
    input  i_flush, i_enq_vld, i_enq_data, i_deq_req,
    output o_can_enq, o_deq_vld, o_deq_data, o_count
  );
endinterface

// File: rtl/ordered_issue_queue.sv
// Multi-port in-order queue: compacts a sparse enqueue mask into program order and
// presents the oldest OUTPORT_NUM entries as a dense window for prefix retirement.
module ordered_issue_queue #(
  parameter type dtype       = logic,
  parameter int  INPORT_NUM  = 4,
  parameter int  OUTPORT_NUM = 4,
  parameter int  DEPTH       = 16
) (
  input  logic clk,
  input  logic rst,
  ordered_issue_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  dtype          mem_q [DEPTH];

  logic [PW-1:0] count;
  logic          can_enq;
  logic          enq_fire;
  logic [PW-1:0] enq_n;
  logic [PW-1:0] deq_n;
  logic [PW-1:0] deq_n_safe;
  logic [PW-1:0] enq_off [INPORT_NUM];
  logic [PW-1:0] wr_ptr  [INPORT_NUM];
  logic [PW-1:0] rd_ptr  [OUTPORT_NUM];

  always_comb begin
    count   = tail_q - head_q;
    can_enq = (count <= PW'(DEPTH - INPORT_NUM));

    // Each valid port lands after all lower-numbered valid ports; gaps are squeezed out.
    enq_n = '0;
    for (int i = 0; i < INPORT_NUM; i++) begin
      enq_off[i] = enq_n;
      wr_ptr[i]  = tail_q + enq_n;
      if (q.i_enq_vld[i]) enq_n = enq_n + PW'(1);
    end

    deq_n = '0;
    for (int k = 0; k < OUTPORT_NUM; k++) begin
      if (q.i_deq_req[k]) deq_n = deq_n + PW'(1);
    end
    // Clamp so a malformed request can never move head past tail.
    deq_n_safe = (deq_n > count) ? count : deq_n;

    enq_fire = can_enq & (|q.i_enq_vld) & ~q.i_flush;

    if (q.i_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = head_q + deq_n_safe;
      tail_d = enq_fire ? (tail_q + enq_n) : tail_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INPORT_NUM; i++) begin
      if (rst && enq_fire && q.i_enq_vld[i]) mem_q[wr_ptr[i][AW-1:0]] <= q.i_enq_data[i];
    end
  end

  always_comb begin
    for (int k = 0; k < OUTPORT_NUM; k++) begin
      rd_ptr[k]       = head_q + PW'(k);
      q.o_deq_vld[k]  = (PW'(k) < count);
      q.o_deq_data[k] = q.o_deq_vld[k] ? mem_q[rd_ptr[k][AW-1:0]] : '0;
    end
    q.o_can_enq = can_enq;
    q.o_count   = count;
  end

  deq_req_is_window_prefix: assert property (
    @(posedge clk) disable iff (!rst)
    !q.i_flush |-> (((q.i_deq_req & (q.i_deq_req + OUTPORT_NUM'(1))) == '0) &&
                    ((q.i_deq_req & ~q.o_deq_vld) == '0))
  );
endmodule
